alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Control-side driver for the datapath ALU. It accepts one decoded ALU instruction and
//  steps it through T-states, driving register-select, bus strobes, Yin/Zin, Zlow/Zhigh
//  read-out and write-back enables, and it drives the 5-bit ALU op code into the ALU.
//  Sits between the instruction decoder and the datapath bus. One instruction in flight at a time.
// PARAMETERS
//  OP_W      5  ALU op-code width (matches the ALU control input)
//  RSEL_W    4  register-select width (16 GPRs)
//  SHAMT_W   5  shift/rotate repeat-count width
// PORTS
//  clock        in   1        single clock; all state changes on rising edge
//  clear_n      in   1        synchronous, active-low reset
//  req_valid    in   1        decoder presents an instruction
//  req_ready    out  1        sequencer idle; request is accepted on valid&ready
//  req_op       in   OP_W     ALU op code
//  req_ra       in   RSEL_W   destination register
//  req_rb       in   RSEL_W   first source register (goes to Y)
//  req_rc       in   RSEL_W   second source register (goes on bus)
//  req_shamt    in   SHAMT_W  repeat count for SHR/SHL/ROR/ROL
//  rsel         out  RSEL_W   register-file select for rout/rin
//  rout         out  1        selected GPR drives bus
//  rin          out  1        selected GPR loads from bus
//  yin          out  1        Y register loads from bus
//  zin          out  1        Z register captures ALU high/low results
//  zlow_out     out  1        Zlow drives bus
//  zhigh_out    out  1        Zhigh drives bus
//  lo_in        out  1        LO register loads from bus
//  hi_in        out  1        HI register loads from bus
//  alu_control  out  OP_W     op code to ALU; 5'b00000 when not in T4
//  done         out  1        one-cycle pulse in the final T-state
//  err          out  1        one-cycle pulse with done for an illegal op
// BEHAVIOUR
//  Op codes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001,
//   OR 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001. Every other code is illegal.
//  Reset (clear_n=0 at an edge): state=IDLE, req_ready=1, and all other outputs 0. This applies
//   mid-operation too: the instruction is abandoned and no write-back occurs.
//  On accept, latch op/ra/rb/rc and iter=max(shamt,1). The latched fields hold until IDLE.
//  States are IDLE, T3, T4, T5, T6, ERR. Outputs are Moore-decoded from the registered state
//   and the latched fields.
//  T3: rsel=rb (iteration>1: rsel=ra), rout=1, yin=1.
//  T4: alu_control=op, zin=1. The bus source depends on the op class:
//   - binary ops (ADD..OR, MUL, DIV): rsel=rc, rout=1
//   - NEG/NOT: rsel=rb, rout=1
//   - shifts/rotates: rout=0
//  T5: zlow_out=1. MUL/DIV: lo_in=1. Other ops: rin=1, rsel=ra.
//  T6 (MUL/DIV only): zhigh_out=1, hi_in=1.
//  Flows and latency (accept edge -> done pulse):
//   - binary non-MUL/DIV: T3->T4->T5(done); 3 cycles
//   - MUL/DIV: T3->T4->T5->T6(done); 4 cycles
//   - NEG/NOT: T4->T5(done), no T3; 2 cycles
//   - shifts/rotates: T3,T4,T5 repeated iter times, iter decremented at the end of each T5;
//     done in the last T5; 3*iter cycles
//   - illegal op: ERR for one cycle with done=1, err=1 and no strobes
//  After done, the next state is IDLE and req_ready=1 on the following cycle. There is no
//   back-to-back accept in the done cycle.
//  req_valid is ignored outside IDLE. Request fields only need to be stable in the accept cycle.
//  shamt=0 behaves as 1 and shamt=31 gives 31 iterations; the counter never wraps.
// STRUCTURE
//  Include file alu_ops.vh: op-code localparams, state encodings, op-class codes.
//  Sub-module alu_op_decode (combinational): op -> {is_binary, is_shift, is_unary,
//   is_muldiv, illegal}. The sequencer FSM, iteration counter and output decode stay top-level.
// TESTING
//  ADD ra=1 rb=2 rc=3 -> T3 rsel=2/rout/yin, T4 rsel=3/alu_control=00011/zin, T5 rsel=1/rin/zlow_out+done; ready back at cycle 4.
//  MUL rb=4 rc=5 -> T5 zlow_out+lo_in (rin=0), T6 zhigh_out+hi_in+done; 4-cycle latency.
//  NOT ra=6 rb=7 -> no yin; T4 rsel=7/rout/alu_control=10001; T5 rin rsel=6 + done; 2 cycles.
//  ROL shamt=3 ra=8 rb=9 -> 9 cycles; first T3 rsel=9, 2nd/3rd T3 rsel=8; rout=0 in every T4; shamt=0 -> 3 cycles.
//  op=01100 -> done=1, err=1 one cycle later, all strobes 0; ready next cycle.
//  clear_n=0 during T4 of DIV -> next cycle IDLE, ready=1, no lo_in/hi_in/done ever pulses.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// Module  : alu_op_sequencer_pkg
// Brief   : ALU op codes, sequencer state encoding and op-class helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_op_sequencer_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_BINARY  = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_UNARY   = 3'd2,
        CLS_SHIFT   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR:  op_class = CLS_BINARY;
            OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
            OP_NEG, OP_NOT:                 op_class = CLS_UNARY;
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_SHIFT;
            default:                        op_class = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
// ----------------------------------------------------------------------------
// Module  : alu_op_decode
// Brief   : Combinational op-code classifier for the ALU op sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_op_decode #(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] op,
    output logic            is_binary,
    output logic            is_shift,
    output logic            is_unary,
    output logic            is_muldiv,
    output logic            illegal
);
    import alu_op_sequencer_pkg::*;

    op_class_t w_cls;

    // Codes wider than the defined 5 bits are illegal if any upper bit is set.
    always_comb begin
        w_cls = op_class(op[4:0]);
        if (OP_W > 5 && (op >> 5) != '0) begin
            w_cls = CLS_ILLEGAL;
        end
    end

    assign is_muldiv = (w_cls == CLS_MULDIV);
    assign is_binary = (w_cls == CLS_BINARY) || is_muldiv;
    assign is_shift  = (w_cls == CLS_SHIFT);
    assign is_unary  = (w_cls == CLS_UNARY);
    assign illegal   = (w_cls == CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// Module  : alu_op_sequencer
// Brief   : Steps one decoded ALU instruction through T3..T6, driving datapath strobes.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer #(
    parameter int OP_W    = 5,
    parameter int RSEL_W  = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_W-1:0]    req_op,
    input  logic [RSEL_W-1:0]  req_ra,
    input  logic [RSEL_W-1:0]  req_rb,
    input  logic [RSEL_W-1:0]  req_rc,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic [RSEL_W-1:0]  rsel,
    output logic               rout,
    output logic               rin,
    output logic               yin,
    output logic               zin,
    output logic               zlow_out,
    output logic               zhigh_out,
    output logic               lo_in,
    output logic               hi_in,
    output logic [OP_W-1:0]    alu_control,
    output logic               done,
    output logic               err
);
    import alu_op_sequencer_pkg::*;

    state_t              r_state, w_state;
    logic [OP_W-1:0]     r_op;
    logic [RSEL_W-1:0]   r_ra, r_rb, r_rc;
    logic [SHAMT_W-1:0]  r_iter, w_iter;
    logic                r_first, w_first;

    logic                w_accept;
    logic [OP_W-1:0]     w_op;
    logic [RSEL_W-1:0]   w_ra, w_rb, w_rc;
    logic                w_binary, w_shift, w_unary, w_muldiv, w_illegal;

    logic [RSEL_W-1:0]   w_rsel;
    logic                w_rout, w_rin, w_yin, w_zin, w_zlow, w_zhigh, w_lo, w_hi;
    logic [OP_W-1:0]     w_alu;
    logic                w_done, w_err, w_ready;

    // Fields as they will be held next cycle; decoding these lets outputs be registered.
    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_op     = w_accept ? req_op : r_op;
    assign w_ra     = w_accept ? req_ra : r_ra;
    assign w_rb     = w_accept ? req_rb : r_rb;
    assign w_rc     = w_accept ? req_rc : r_rc;

    alu_op_decode #(.OP_W(OP_W)) u_decode (
        .op        (w_op),
        .is_binary (w_binary),
        .is_shift  (w_shift),
        .is_unary  (w_unary),
        .is_muldiv (w_muldiv),
        .illegal   (w_illegal)
    );

    always_comb begin
        w_state = r_state;
        w_iter  = r_iter;
        w_first = r_first;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_iter  = (req_shamt == '0) ? SHAMT_W'(1) : req_shamt;
                    w_first = 1'b1;
                    if (w_illegal)     w_state = ST_ERR;
                    else if (w_unary)  w_state = ST_T4;
                    else               w_state = ST_T3;
                end
            end
            ST_T3: w_state = ST_T4;
            ST_T4: w_state = ST_T5;
            ST_T5: begin
                if (w_muldiv) begin
                    w_state = ST_T6;
                end else if (w_shift && r_iter > SHAMT_W'(1)) begin
                    w_state = ST_T3;
                    w_iter  = r_iter - SHAMT_W'(1);
                    w_first = 1'b0;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // Moore output decode for the state being entered.
    always_comb begin
        w_rsel  = '0;
        w_rout  = 1'b0;
        w_rin   = 1'b0;
        w_yin   = 1'b0;
        w_zin   = 1'b0;
        w_zlow  = 1'b0;
        w_zhigh = 1'b0;
        w_lo    = 1'b0;
        w_hi    = 1'b0;
        w_alu   = '0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_ready = 1'b0;
        case (w_state)
            ST_IDLE: w_ready = 1'b1;
            ST_T3: begin
                w_rsel = w_first ? w_rb : w_ra;
                w_rout = 1'b1;
                w_yin  = 1'b1;
            end
            ST_T4: begin
                w_alu = w_op;
                w_zin = 1'b1;
                if (w_binary) begin
                    w_rsel = w_rc;
                    w_rout = 1'b1;
                end else if (w_unary) begin
                    w_rsel = w_rb;
                    w_rout = 1'b1;
                end
            end
            ST_T5: begin
                w_zlow = 1'b1;
                if (w_muldiv) begin
                    w_lo = 1'b1;
                end else begin
                    w_rin  = 1'b1;
                    w_rsel = w_ra;
                    w_done = !w_shift || (w_iter == SHAMT_W'(1));
                end
            end
            ST_T6: begin
                w_zhigh = 1'b1;
                w_hi    = 1'b1;
                w_done  = 1'b1;
            end
            ST_ERR: begin
                w_done = 1'b1;
                w_err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_rc        <= '0;
            r_iter      <= '0;
            r_first     <= 1'b0;
            req_ready   <= 1'b1;
            rsel        <= '0;
            rout        <= 1'b0;
            rin         <= 1'b0;
            yin         <= 1'b0;
            zin         <= 1'b0;
            zlow_out    <= 1'b0;
            zhigh_out   <= 1'b0;
            lo_in       <= 1'b0;
            hi_in       <= 1'b0;
            alu_control <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_ra        <= w_ra;
            r_rb        <= w_rb;
            r_rc        <= w_rc;
            r_iter      <= w_iter;
            r_first     <= w_first;
            req_ready   <= w_ready;
            rsel        <= w_rsel;
            rout        <= w_rout;
            rin         <= w_rin;
            yin         <= w_yin;
            zin         <= w_zin;
            zlow_out    <= w_zlow;
            zhigh_out   <= w_zhigh;
            lo_in       <= w_lo;
            hi_in       <= w_hi;
            alu_control <= w_alu;
            done        <= w_done;
            err         <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// Module  : tb_alu_op_sequencer
// Brief   : Directed self-checking bench for alu_op_sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_op = '0;
    logic [3:0] req_ra = '0, req_rb = '0, req_rc = '0;
    logic [4:0] req_shamt = '0;
    logic [3:0] rsel;
    logic       rout, rin, yin, zin, zlow_out, zhigh_out, lo_in, hi_in;
    logic [4:0] alu_control;
    logic       done, err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_sequencer dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_ra      (req_ra),
        .req_rb      (req_rb),
        .req_rc      (req_rc),
        .req_shamt   (req_shamt),
        .rsel        (rsel),
        .rout        (rout),
        .rin         (rin),
        .yin         (yin),
        .zin         (zin),
        .zlow_out    (zlow_out),
        .zhigh_out   (zhigh_out),
        .lo_in       (lo_in),
        .hi_in       (hi_in),
        .alu_control (alu_control),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Observed bundle: rsel | rout rin yin zin zlow zhigh lo hi | alu | done err ready
    logic [19:0] obs;
    assign obs = {rsel, rout, rin, yin, zin, zlow_out, zhigh_out, lo_in, hi_in,
                  alu_control, done, err, req_ready};

    function automatic logic [19:0] ev(input logic [3:0] rs, input logic [7:0] st,
                                       input logic [4:0] alu, input logic d,
                                       input logic e, input logic rdy);
        return {rs, st, alu, d, e, rdy};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [4:0] sh);
        req_valid = 1'b1;
        req_op    = op;
        req_ra    = ra;
        req_rb    = rb;
        req_rc    = rc;
        req_shamt = sh;
        tick();
        req_valid = 1'b0;
        req_op    = '0;
        req_ra    = '0;
        req_rb    = '0;
        req_rc    = '0;
        req_shamt = '0;
    endtask

    localparam logic [19:0] IDLE_V = 20'h00001;

    initial begin
        int n;
        tick();
        tick();
        chk("reset_idle", IDLE_V);
        clear_n = 1'b1;

        // ADD ra=1 rb=2 rc=3; a request during T3 must be ignored
        issue(5'b00011, 4'd1, 4'd2, 4'd3, 5'd0);
        chk("add_t3", ev(4'd2, 8'b1010_0000, 5'b00000, 1'b0, 1'b0, 1'b0));
        req_valid = 1'b1;
        req_op    = 5'b10001;
        req_rc    = 4'd9;
        tick();
        req_valid = 1'b0;
        chk("add_t4", ev(4'd3, 8'b1001_0000, 5'b00011, 1'b0, 1'b0, 1'b0));
        tick();
        chk("add_t5", ev(4'd1, 8'b0100_1000, 5'b00000, 1'b1, 1'b0, 1'b0));
        tick();
        chk("add_idle", IDLE_V);

        // MUL ra=2 rb=4 rc=5
        issue(5'b01110, 4'd2, 4'd4, 4'd5, 5'd0);
        chk("mul_t3", ev(4'd4, 8'b1010_0000, 5'b00000, 1'b0, 1'b0, 1'b0));
        tick();
        chk("mul_t4", ev(4'd5, 8'b1001_0000, 5'b01110, 1'b0, 1'b0, 1'b0));
        tick();
        chk("mul_t5", ev(4'd0, 8'b0000_1010, 5'b00000, 1'b0, 1'b0, 1'b0));
        tick();
        chk("mul_t6", ev(4'd0, 8'b0000_0101, 5'b00000, 1'b1, 1'b0, 1'b0));
        tick();
        chk("mul_idle", IDLE_V);

        // NOT ra=6 rb=7
        issue(5'b10001, 4'd6, 4'd7, 4'd2, 5'd0);
        chk("not_t4", ev(4'd7, 8'b1001_0000, 5'b10001, 1'b0, 1'b0, 1'b0));
        tick();
        chk("not_t5", ev(4'd6, 8'b0100_1000, 5'b00000, 1'b1, 1'b0, 1'b0));
        tick();
        chk("not_idle", IDLE_V);

        // ROL shamt=3 ra=8 rb=9
        issue(5'b01000, 4'd8, 4'd9, 4'd4, 5'd3);
        for (int it = 0; it < 3; it++) begin
            if (it != 0) tick();
            chk($sformatf("rol_t3_%0d", it),
                ev((it == 0) ? 4'd9 : 4'd8, 8'b1010_0000, 5'b00000, 1'b0, 1'b0, 1'b0));
            tick();
            chk($sformatf("rol_t4_%0d", it), ev(4'd0, 8'b0001_0000, 5'b01000, 1'b0, 1'b0, 1'b0));
            tick();
            chk($sformatf("rol_t5_%0d", it),
                ev(4'd8, 8'b0100_1000, 5'b00000, (it == 2), 1'b0, 1'b0));
        end
        tick();
        chk("rol_idle", IDLE_V);

        // ROL shamt=0 behaves as one iteration
        issue(5'b01000, 4'd1, 4'd2, 4'd3, 5'd0);
        chk("rol0_t3", ev(4'd2, 8'b1010_0000, 5'b00000, 1'b0, 1'b0, 1'b0));
        tick();
        chk("rol0_t4", ev(4'd0, 8'b0001_0000, 5'b01000, 1'b0, 1'b0, 1'b0));
        tick();
        chk("rol0_t5", ev(4'd1, 8'b0100_1000, 5'b00000, 1'b1, 1'b0, 1'b0));
        tick();
        chk("rol0_idle", IDLE_V);

        // SHR shamt=31: latency 93 cycles
        issue(5'b00101, 4'd5, 4'd6, 4'd7, 5'd31);
        n = 1;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk_int("shr31_latency", n, 93);
        tick();
        chk("shr31_idle", IDLE_V);

        // Illegal op
        issue(5'b01100, 4'd1, 4'd2, 4'd3, 5'd0);
        chk("ill_err", ev(4'd0, 8'b0000_0000, 5'b00000, 1'b1, 1'b1, 1'b0));
        tick();
        chk("ill_idle", IDLE_V);

        // Reset during T4 of DIV
        issue(5'b01111, 4'd3, 4'd4, 4'd5, 5'd0);
        tick();
        chk("div_t4", ev(4'd5, 8'b1001_0000, 5'b01111, 1'b0, 1'b0, 1'b0));
        clear_n = 1'b0;
        tick();
        chk("div_abort_idle", IDLE_V);
        clear_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("div_quiet_%0d", k), IDLE_V);
        end

        // Back-to-back usable after abort
        issue(5'b00100, 4'd10, 4'd11, 4'd12, 5'd0);
        chk("sub_t3", ev(4'd11, 8'b1010_0000, 5'b00000, 1'b0, 1'b0, 1'b0));
        tick();
        chk("sub_t4", ev(4'd12, 8'b1001_0000, 5'b00100, 1'b0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
